seq_trigger2: RTL and testbench



---
 rtl/seq_trigger2_pkg.sv | 46 ++++
 rtl/seq_age_tracker.sv | 42 ++++
 rtl/seq_trigger2.sv | 75 +++++++
 tb/tb_seq_trigger2.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seq_trigger2_pkg.sv
// seq_trigger2_pkg
//   Shared constants and helpers for the seq_trigger2 load/done sequence
//   detector.
//   - DEF_MIN_DLY / DEF_MAX_DLY : default eligibility window (clocks).
//   - AGE_W                     : width of the age vectors the helpers use
//                                 (covers the largest allowed MAX_DLY).
//   - window_mask()             : bit (k-1) set for every age k in [min, max].
//   - oldest_eligible()         : one-hot mask of the oldest set age inside
//                                 [min, max], or zero when nothing is set.
package seq_trigger2_pkg;

    localparam int unsigned DEF_MIN_DLY = 1;
    localparam int unsigned DEF_MAX_DLY = 5;
    localparam int unsigned AGE_W       = 16;

    // Bit (k-1) represents an event sampled k edges ago.
    function automatic logic [AGE_W-1:0] window_mask(input int unsigned min_dly,
                                                     input int unsigned max_dly);
        logic [AGE_W-1:0] m;
        m = '0;
        for (int k = 1; k <= int'(AGE_W); k++) begin
            if (k >= int'(min_dly) && k <= int'(max_dly)) begin
                m[k-1] = 1'b1;
            end
        end
        return m;
    endfunction

    // Scan from the largest age down so the first hit is the oldest entry.
    function automatic logic [AGE_W-1:0] oldest_eligible(input logic [AGE_W-1:0] pend,
                                                         input int unsigned min_dly,
                                                         input int unsigned max_dly);
        logic [AGE_W-1:0] res;
        logic             found;
        res   = '0;
        found = 1'b0;
        for (int k = int'(AGE_W); k >= 1; k--) begin
            if (!found && k >= int'(min_dly) && k <= int'(max_dly) && pend[k-1]) begin
                res[k-1] = 1'b1;
                found    = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_age_tracker.sv
// seq_age_tracker
//   Shift register of event ages with per-entry consume. Bit i of vec_o means
//   an event sampled (i+1) edges ago that has not been consumed. Each edge the
//   consumed entries are cleared, everything ages by one, load_i enters at age
//   1 and the entry at age DEPTH falls off.
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset, clears all entries
//     load_i    : new event sampled this edge
//     consume_i : entries to clear before aging (bit i = age i+1)
//     vec_o     : current age vector
module seq_age_tracker #(
    parameter int unsigned DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [DEPTH-1:0] consume_i,
    output logic [DEPTH-1:0] vec_o
);

    logic [DEPTH-1:0] vec_q;
    logic [DEPTH-1:0] vec_d;
    logic [DEPTH-1:0] kept;

    always_comb begin
        kept  = vec_q & ~consume_i;
        // The left shift drops the oldest entry, which is how expiry happens.
        vec_d = (kept << 1) | DEPTH'(load_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= '0;
        end else begin
            vec_q <= vec_d;
        end
    end

    assign vec_o = vec_q;

endmodule

// File: rtl/seq_trigger2.sv
// seq_trigger2
//   Flags "load_mem, then done within MIN_DLY..MAX_DLY clocks".
//   Ports:
//     clk      : clock, rising edge
//     rst_n    : asynchronous active-low reset
//     load_mem : load start event
//     done     : load completion event
//     ready    : registered, any qualifying earlier load (non-consuming)
//     ready2   : registered, oldest unconsumed qualifying load is paired with
//                this done and removed (consuming)
module seq_trigger2
    import seq_trigger2_pkg::*;
#(
    parameter int unsigned MIN_DLY = DEF_MIN_DLY,
    parameter int unsigned MAX_DLY = DEF_MAX_DLY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_mem,
    input  logic done,
    output logic ready,
    output logic ready2
);

    localparam logic [AGE_W-1:0] WIN_EXT = window_mask(MIN_DLY, MAX_DLY);

    logic [MAX_DLY-1:0] hist_vec;
    logic [MAX_DLY-1:0] pend_vec;
    logic [MAX_DLY-1:0] pend_consume;
    logic [AGE_W-1:0]   pend_ext;
    logic [AGE_W-1:0]   oldest_ext;
    logic               ready_q,  ready_d;
    logic               ready2_q, ready2_d;

    // Plain history: never consumed, only ages out.
    seq_age_tracker #(.DEPTH(MAX_DLY)) u_hist (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load_mem),
        .consume_i ({MAX_DLY{1'b0}}),
        .vec_o     (hist_vec)
    );

    // Pending loads: a matching done removes the oldest eligible one.
    seq_age_tracker #(.DEPTH(MAX_DLY)) u_pend (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load_mem),
        .consume_i (pend_consume),
        .vec_o     (pend_vec)
    );

    always_comb begin
        pend_ext               = '0;
        pend_ext[MAX_DLY-1:0]  = pend_vec;
        oldest_ext             = oldest_eligible(pend_ext, MIN_DLY, MAX_DLY);
        pend_consume           = done ? oldest_ext[MAX_DLY-1:0] : '0;
        ready_d                = done && |(hist_vec & WIN_EXT[MAX_DLY-1:0]);
        ready2_d               = done && |oldest_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= 1'b0;
            ready2_q <= 1'b0;
        end else begin
            ready_q  <= ready_d;
            ready2_q <= ready2_d;
        end
    end

    assign ready  = ready_q;
    assign ready2 = ready2_q;

endmodule

// File: tb/tb_seq_trigger2.sv
module tb_seq_trigger2;

    localparam int MIN_DLY = 1;
    localparam int MAX_DLY = 5;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_mem = 1'b0;
    logic done = 1'b0;
    logic ready;
    logic ready2;

    always #5 clk = ~clk;

    seq_trigger2 #(.MIN_DLY(MIN_DLY), .MAX_DLY(MAX_DLY)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_mem (load_mem),
        .done     (done),
        .ready    (ready),
        .ready2   (ready2)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // reference model: edge numbers of sampled loads
    int   edge_no = 0;
    int   load_edges[$];   // all recent loads (non-consuming view)
    int   pend_edges[$];   // unconsumed loads, oldest first
    logic exp_ready = 1'b0;
    logic exp_ready2 = 1'b0;

    function automatic void model_edge(input logic l, input logic d);
        int idx;
        // drop loads too old to ever match again
        while (load_edges.size() > 0 && edge_no - load_edges[0] > MAX_DLY) void'(load_edges.pop_front());
        while (pend_edges.size() > 0 && edge_no - pend_edges[0] > MAX_DLY) void'(pend_edges.pop_front());
        exp_ready = 1'b0;
        if (d) begin
            foreach (load_edges[i]) begin
                if (edge_no - load_edges[i] >= MIN_DLY) exp_ready = 1'b1;
            end
        end
        exp_ready2 = 1'b0;
        idx = -1;
        if (d) begin
            foreach (pend_edges[i]) begin
                if (idx < 0 && edge_no - pend_edges[i] >= MIN_DLY) idx = i;
            end
        end
        if (idx >= 0) begin
            pend_edges.delete(idx);
            exp_ready2 = 1'b1;
        end
        if (l) begin
            load_edges.push_back(edge_no);
            pend_edges.push_back(edge_no);
        end
        edge_no++;
    endfunction

    // driver: called at a falling edge, returns at the next falling edge
    task automatic cycle(input logic l, input logic d, input string tag);
        load_mem = l;
        done     = d;
        @(posedge clk);
        model_edge(l, d);
        @(negedge clk);
        check_bit({tag, "_ready"},  ready,  exp_ready);
        check_bit({tag, "_ready2"}, ready2, exp_ready2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, "idle");
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        load_mem = 1'b0;
        done = 1'b0;
        #1;
        check_bit("rst_fall_ready",  ready,  1'b0);
        check_bit("rst_fall_ready2", ready2, 1'b0);
        load_edges.delete();
        pend_edges.delete();
        exp_ready = 1'b0;
        exp_ready2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("rst_hold_ready",  ready,  1'b0);
        check_bit("rst_hold_ready2", ready2, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        apply_reset();

        // reset mid-operation: load, done (outputs high), then reset
        cycle(1'b1, 1'b0, "pre_rst_load");
        cycle(1'b0, 1'b1, "pre_rst_done");
        check_bit("pre_rst_ready_hi", ready, 1'b1);
        apply_reset();
        cycle(1'b0, 1'b1, "post_rst_done");
        check_bit("post_rst_ready_lo",  ready,  1'b0);
        check_bit("post_rst_ready2_lo", ready2, 1'b0);
        idle(MAX_DLY + 1);

        // window lower edge: done one edge after load
        cycle(1'b1, 1'b0, "win_min_load");
        cycle(1'b0, 1'b1, "win_min_done");
        check_bit("win_min_ready",  ready,  1'b1);
        check_bit("win_min_ready2", ready2, 1'b1);
        idle(MAX_DLY + 1);

        // window upper edge: done MAX_DLY edges after load
        cycle(1'b1, 1'b0, "win_max_load");
        idle(MAX_DLY - 1);
        cycle(1'b0, 1'b1, "win_max_done");
        check_bit("win_max_ready",  ready,  1'b1);
        check_bit("win_max_ready2", ready2, 1'b1);
        idle(MAX_DLY + 1);

        // past window: done MAX_DLY+1 edges after load
        cycle(1'b1, 1'b0, "win_out_load");
        idle(MAX_DLY);
        cycle(1'b0, 1'b1, "win_out_done");
        check_bit("win_out_ready",  ready,  1'b0);
        check_bit("win_out_ready2", ready2, 1'b0);
        idle(MAX_DLY + 1);

        // same-cycle load and done, then done next edge
        cycle(1'b1, 1'b1, "same_cyc");
        check_bit("same_cyc_ready",  ready,  1'b0);
        check_bit("same_cyc_ready2", ready2, 1'b0);
        cycle(1'b0, 1'b1, "same_next");
        check_bit("same_next_ready",  ready,  1'b1);
        check_bit("same_next_ready2", ready2, 1'b1);
        idle(MAX_DLY + 1);

        // one load, two dones: consuming vs non-consuming
        cycle(1'b1, 1'b0, "cons_load");
        cycle(1'b0, 1'b1, "cons_d1");
        check_bit("cons_d1_ready",  ready,  1'b1);
        check_bit("cons_d1_ready2", ready2, 1'b1);
        cycle(1'b0, 1'b1, "cons_d2");
        check_bit("cons_d2_ready",  ready,  1'b1);
        check_bit("cons_d2_ready2", ready2, 1'b0);
        idle(MAX_DLY + 1);

        // two loads, three dones
        cycle(1'b1, 1'b0, "two_l1");
        cycle(1'b1, 1'b0, "two_l2");
        cycle(1'b0, 1'b0, "two_gap");
        cycle(1'b0, 1'b1, "two_d1");
        check_bit("two_d1_ready2", ready2, 1'b1);
        cycle(1'b0, 1'b1, "two_d2");
        check_bit("two_d2_ready2", ready2, 1'b1);
        cycle(1'b0, 1'b1, "two_d3");
        check_bit("two_d3_ready",  ready,  1'b1);
        check_bit("two_d3_ready2", ready2, 1'b0);
        idle(MAX_DLY + 1);

        // randomized traffic against the reference model
        for (int i = 0; i < 100; i++) begin
            cycle(($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 45), "rand");
        end
        for (int i = 0; i < 200; i++) begin
            cycle(($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 70), "rand_sparse");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
